// File: rtl/dmem_responder_if.sv
// D-cache <-> memory responder bus. The D-cache is the master and the responder is the slave.
interface dmem_responder_if #(
    parameter int XLEN = 32
);
    logic [1:0]      proc2Dmem_command;
    logic [XLEN-1:0] proc2Dmem_addr;
    logic [63:0]     proc2Dmem_data;
    logic [3:0]      Dmem2proc_response;
    logic [63:0]     Dmem2proc_data;
    logic [3:0]      Dmem2proc_tag;

    modport master (
        output proc2Dmem_command,
        output proc2Dmem_addr,
        output proc2Dmem_data,
        input  Dmem2proc_response,
        input  Dmem2proc_data,
        input  Dmem2proc_tag
    );

    modport slave (
        input  proc2Dmem_command,
        input  proc2Dmem_addr,
        input  proc2Dmem_data,
        output Dmem2proc_response,
        output Dmem2proc_data,
        output Dmem2proc_tag
    );
endinterface

// File: rtl/dmem_responder.sv
// Memory-side responder for the D-cache bus.
// It holds a 64-bit-word backing store and grants the lowest free tag to each LOAD or STORE.
// Accepted loads return {tag, data} exactly LATENCY cycles later on a shift pipeline.
// MEM_WORDS is expected to be a power of two, because the index is taken from addr[3 +: log2(MEM_WORDS)].
module dmem_responder #(
    parameter int NUM_TAGS  = 15,
    parameter int LATENCY   = 4,
    parameter int MEM_WORDS = 8192
) (
    input  logic             clk,
    input  logic             reset,   // asynchronous, active-low
    dmem_responder_if.slave  bus
);
    localparam int         IDX_W     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [1:0] BUS_LOAD  = 2'd1;
    localparam logic [1:0] BUS_STORE = 2'd2;

    logic [63:0]       mem [MEM_WORDS];
    logic [NUM_TAGS:1] busy_q;
    logic [LATENCY:1]  vld_q;
    logic [3:0]        tag_q  [1:LATENCY];
    logic [63:0]       data_q [1:LATENCY];

    logic              is_load;
    logic              is_store;
    logic [3:0]        free_tag;
    logic [3:0]        response;
    logic              load_acc;
    logic              store_acc;
    logic [IDX_W-1:0]  idx;
    logic              unused_addr_bits;

    assign is_load   = (bus.proc2Dmem_command == BUS_LOAD);
    assign is_store  = (bus.proc2Dmem_command == BUS_STORE);
    assign idx       = bus.proc2Dmem_addr[3 +: IDX_W];
    // Only the word-index bits of the address select a word.
    assign unused_addr_bits = ^bus.proc2Dmem_addr;

    // Find the lowest-numbered tag whose busy bit is clear. The result is 0 when every tag is busy.
    always_comb begin
        free_tag = '0;
        for (int t = NUM_TAGS; t >= 1; t--) begin
            if (!busy_q[t]) begin
                free_tag = 4'(t);
            end
        end
    end

    // A request is granted only outside reset, only for LOAD or STORE, and only when a tag is free.
    assign response  = (reset && (is_load || is_store)) ? free_tag : 4'd0;
    assign load_acc  = is_load  && (response != 4'd0);
    assign store_acc = is_store && (response != 4'd0);

    // Each tag has its own busy bit.
    // An accepted load sets the bit. The bit clears at the edge that ends the tag's broadcast cycle.
    for (genvar gi = 1; gi <= NUM_TAGS; gi++) begin : g_busy
        logic busy_d;

        // Next state of this tag's busy bit.
        always_comb begin
            busy_d = busy_q[gi];
            if (vld_q[LATENCY] && (tag_q[LATENCY] == 4'(gi))) begin
                busy_d = 1'b0;
            end
            if (load_acc && (response == 4'(gi))) begin
                busy_d = 1'b1;
            end
        end

        // Busy bit register. Reset frees the tag.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                busy_q[gi] <= 1'b0;
            end else begin
                busy_q[gi] <= busy_d;
            end
        end
    end

    // Valid and tag shift pipeline. Reset drops every in-flight load.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_q <= '0;
            for (int s = 1; s <= LATENCY; s++) begin
                tag_q[s] <= '0;
            end
        end else begin
            vld_q[1] <= load_acc;
            tag_q[1] <= response;
            for (int s = 2; s <= LATENCY; s++) begin
                vld_q[s] <= vld_q[s-1];
                tag_q[s] <= tag_q[s-1];
            end
        end
    end

    // Backing store and data pipeline.
    // The read is registered into stage 1 on every cycle, so a load snapshots the word at acceptance.
    // Only one request is accepted per cycle, so a read and a write never target the same cycle.
    always_ff @(posedge clk) begin
        if (store_acc) begin
            mem[idx] <= bus.proc2Dmem_data;
        end
        data_q[1] <= mem[idx];
        for (int s = 2; s <= LATENCY; s++) begin
            data_q[s] <= data_q[s-1];
        end
    end

    assign bus.Dmem2proc_response = response;
    assign bus.Dmem2proc_tag      = vld_q[LATENCY] ? tag_q[LATENCY]  : 4'd0;
    assign bus.Dmem2proc_data     = vld_q[LATENCY] ? data_q[LATENCY] : 64'd0;
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder.
// The same command stream drives two instances, one with LATENCY=4 and one with LATENCY=20.
// Each instance has its own reference model of tag occupancy and memory contents.
module tb_dmem_responder;
    localparam int NT = 15;

    typedef struct {
        int          tag;
        int          due;
        logic [63:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  cmd;
    logic [31:0] addr;
    logic [63:0] wdata;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    int          pool_idx [8];

    always #5 clk = ~clk;

    // Cycle k runs from posedge k to posedge k+1.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    for (genvar gi = 0; gi < 2; gi++) begin : g_inst
        localparam int L = (gi == 0) ? 4 : 20;

        dmem_responder_if #(.XLEN(32)) bus ();

        assign bus.proc2Dmem_command = cmd;
        assign bus.proc2Dmem_addr    = addr;
        assign bus.proc2Dmem_data    = wdata;

        dmem_responder #(.NUM_TAGS(NT), .LATENCY(L), .MEM_WORDS(8192)) dut (
            .clk   (clk),
            .reset (reset),
            .bus   (bus.slave)
        );

        logic [63:0] mem_m [int];
        int          rel_cyc [16];   // first cycle in which each tag is free again
        exp_t        exp_q [$];

        initial begin
            for (int t = 0; t < 16; t++) rel_cyc[t] = 0;
        end

        // Reference model: predicts the response and pushes the expected load completions.
        always @(negedge clk) begin
            int   exp_resp;
            int   w;
            exp_t e;
            exp_resp = 0;
            w = int'(addr[15:3]);
            if (!reset) begin
                for (int t = 0; t < 16; t++) rel_cyc[t] = 0;
            end else if (cmd == 2'd1 || cmd == 2'd2) begin
                for (int t = NT; t >= 1; t--) begin
                    if (cyc >= rel_cyc[t]) exp_resp = t;
                end
            end
            check($sformatf("L%0d response cyc %0d", L, cyc), 64'(bus.Dmem2proc_response), 64'(exp_resp));
            if (exp_resp != 0) begin
                if (cmd == 2'd1) begin
                    rel_cyc[exp_resp] = cyc + L + 1;
                    e.tag  = exp_resp;
                    e.due  = cyc + L;
                    e.data = mem_m.exists(w) ? mem_m[w] : 64'hx;
                    exp_q.push_back(e);
                end else begin
                    mem_m[w] = wdata;
                end
            end
        end

        // Monitor: pops the completion that falls due in this cycle and compares it with the broadcast.
        always @(negedge clk) begin
            exp_t        e;
            logic [3:0]  et;
            logic [63:0] ed;
            et = 4'd0;
            ed = 64'd0;
            if (!reset) begin
                exp_q.delete();
            end else if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                e  = exp_q.pop_front();
                et = 4'(e.tag);
                ed = e.data;
            end
            if (bus.Dmem2proc_tag != 4'd0)
                $display("L%0d cyc %0d: broadcast tag %0d data %h", L, cyc, bus.Dmem2proc_tag, bus.Dmem2proc_data);
            check($sformatf("L%0d tag cyc %0d", L, cyc), 64'(bus.Dmem2proc_tag), 64'(et));
            check($sformatf("L%0d data cyc %0d", L, cyc), bus.Dmem2proc_data, ed);
        end
    end

    // Drive one cycle of command. A non-negative e4 or e20 is checked as the response of that instance.
    task automatic drive(input logic [1:0] c, input logic [31:0] a, input logic [63:0] d,
                         input int e4, input int e20);
        cmd = c; addr = a; wdata = d;
        #1;
        if (e4 >= 0)  check("L4 directed response",  64'(g_inst[0].bus.Dmem2proc_response), 64'(e4));
        if (e20 >= 0) check("L20 directed response", 64'(g_inst[1].bus.Dmem2proc_response), 64'(e20));
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n, input logic allow3);
        for (int i = 0; i < n; i++) begin
            drive((allow3 && $urandom_range(0, 1) == 1) ? 2'd3 : 2'd0, $urandom,
                  {$urandom, $urandom}, 0, 0);
        end
    endtask

    function automatic logic [31:0] pool_addr(input int k);
        logic [31:0] a;
        a = $urandom;
        a[15:3] = 13'(pool_idx[k]);
        return a;
    endfunction

    localparam logic [63:0] D1 = 64'h1122334455667788;

    initial begin
        logic [63:0] old_a;
        reset = 1'b0; cmd = 2'd0; addr = '0; wdata = '0;
        pool_idx[0] = 32'h100 >> 3;
        for (int k = 1; k < 8; k++) pool_idx[k] = (32'h200 >> 3) + k - 1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        // Store then load: the load returns 4 cycles later, for one cycle only.
        drive(2'd2, 32'h100, D1, 1, 1);
        drive(2'd1, 32'h100, 64'd0, 1, 1);
        for (int i = 0; i < 3; i++) drive(2'd0, 32'h0, 64'd0, -1, -1);
        #1;
        check("L4 first load tag",  64'(g_inst[0].bus.Dmem2proc_tag), 64'd1);
        check("L4 first load data", g_inst[0].bus.Dmem2proc_data, D1);
        drive(2'd0, 32'h0, 64'd0, -1, -1);
        #1;
        check("L4 tag after one cycle", 64'(g_inst[0].bus.Dmem2proc_tag), 64'd0);

        // Fill the word pool. The first pool word is 0x200.
        for (int k = 1; k < 8; k++) drive(2'd2, 32'h200 + 32'(8 * (k - 1)), {$urandom, $urandom}, -1, -1);
        old_a = g_inst[0].mem_m[pool_idx[1]];

        // Address masking.
        drive(2'd1, 32'h105, 64'd0, -1, -1);
        drive(2'd1, 32'h10100, 64'd0, -1, -1);

        // Load/store race on 0x200.
        drive(2'd1, 32'h200, 64'd0, -1, -1);
        drive(2'd2, 32'h200, ~old_a, -1, -1);
        drive(2'd1, 32'h200, 64'd0, -1, -1);

        // Idle commands: NONE and encoding 3 with arbitrary address and data.
        idle(25, 1'b1);

        // Tag exhaustion on the LATENCY=20 instance.
        for (int k = 0; k < 15; k++) drive(2'd1, pool_addr($urandom_range(0, 7)), 64'd0, -1, k + 1);
        drive(2'd1, pool_addr(0), 64'd0, -1, 0);
        idle(4, 1'b0);
        drive(2'd1, pool_addr(1), 64'd0, -1, 0);
        drive(2'd1, pool_addr(2), 64'd0, -1, 1);

        // Randomised traffic.
        for (int i = 0; i < 300; i++) begin
            drive(2'($urandom_range(0, 3)), pool_addr($urandom_range(0, 7)), {$urandom, $urandom}, -1, -1);
        end

        // Mid-flight reset with three loads outstanding.
        idle(22, 1'b0);
        drive(2'd1, 32'h100, 64'd0, 1, 1);
        drive(2'd1, pool_addr(3), 64'd0, 2, 2);
        drive(2'd1, pool_addr(4), 64'd0, 3, 3);
        drive(2'd0, 32'h0, 64'd0, 0, 0);
        #1;
        check("L4 tag before reset", 64'(g_inst[0].bus.Dmem2proc_tag), 64'd1);
        cmd = 2'd1;
        #1 reset = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            check("async reset tag",      64'(i == 0 ? g_inst[0].bus.Dmem2proc_tag : g_inst[1].bus.Dmem2proc_tag), 64'd0);
            check("async reset data",     i == 0 ? g_inst[0].bus.Dmem2proc_data : g_inst[1].bus.Dmem2proc_data, 64'd0);
            check("async reset response", 64'(i == 0 ? g_inst[0].bus.Dmem2proc_response : g_inst[1].bus.Dmem2proc_response), 64'd0);
        end
        repeat (2) @(posedge clk);
        #1 reset = 1'b1; cmd = 2'd0;
        idle(40, 1'b0);
        drive(2'd1, 32'h100, 64'd0, 1, 1);
        idle(25, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Memory-side responder for the data-cache bus: it accepts BUS_LOAD/BUS_STORE requests from the D-cache miss/evict logic, holds a 64-bit-word backing store, and hands out transaction tags. Loads complete a fixed number of cycles later by broadcasting the tag with the line data. It replaces the behavioural memory model in synthesizable regressions and sits directly across the proc2Dmem/Dmem2proc interface from the D-cache.

## Interface
- Parameters:
  - NUM_TAGS, default 15: tags in use are 1..NUM_TAGS; legal range 1–15 (tag 0 means "none").
  - LATENCY, default 4: cycles from load acceptance to data return; must be ≥ 1.
  - MEM_WORDS, default 8192: 64-bit words in the backing store, indexed by addr[15:3].
- Ports:
  - clk, in, 1: sole clock, rising edge.
  - reset, in, 1: reset is asynchronous and active-low (0 = in reset).
  - proc2Dmem_command, in, 2: BUS_NONE=0, BUS_LOAD=1, BUS_STORE=2; encoding 3 is treated as BUS_NONE.
  - proc2Dmem_addr, in, XLEN: byte address; only [15:3] used; [2:0] and [31:16] ignored.
  - proc2Dmem_data, in, 64: store data, whole word.
  - Dmem2proc_response, out, 4: combinational; nonzero tag = request accepted this cycle, 0 = rejected or no request.
  - Dmem2proc_data, out, 64: registered load data, valid only when Dmem2proc_tag ≠ 0.
  - Dmem2proc_tag, out, 4: registered; nonzero for exactly one cycle per completed load.

## Operation
- Tag pool: NUM_TAGS busy bits. A free tag is one whose busy bit is clear.
- Response: if the command is LOAD or STORE and any tag is free, Dmem2proc_response is the lowest-numbered free tag. If no tag is free, the response is 0. For NONE or 3 it is 0.
- Load accepted (response ≠ 0):
  - At the closing edge, the tag's busy bit is set.
  - mem[addr[15:3]] is read at that edge and pushed into stage 1 of a LATENCY-deep pipeline as {valid, tag, data}.
- Store accepted:
  - mem[addr[15:3]] is written with proc2Dmem_data at the closing edge.
  - The tag is not reserved and no data completion is broadcast for it.
  - A rejected store writes nothing.
- Rejected request: no state change. The requester must retry.
- Pipeline: shifts every cycle, with no stall. The final stage drives Dmem2proc_tag and Dmem2proc_data; when that stage is empty, tag = 0 and data = 0.
- Tag release: the busy bit of the broadcast tag clears at the edge closing the broadcast cycle.
- Ordering:
  - A load captures array contents at acceptance, so a later store to the same word does not alter the data in flight.
  - A store followed by a load of the same word returns the new data.
- Reset (reset = 0, asynchronous, any time):
  - Pipeline valids, busy bits, Dmem2proc_tag and Dmem2proc_data clear to 0 immediately.
  - Dmem2proc_response is forced to 0 while in reset.
  - In-flight loads are discarded and never broadcast.
  - The array is not reset; its contents are undefined until written.

## Timing
- Load accepted in cycle T: tag and data are visible during cycle T+LATENCY, for one cycle only.
- That tag is reusable by a request in cycle T+LATENCY+1, not in T+LATENCY.
- With all tags free, the response is 1 in the same cycle as the command.
- At most one request is accepted per cycle. Back-to-back loads in consecutive cycles return in consecutive cycles.
- Maximum outstanding loads is min(NUM_TAGS, LATENCY+1). Rejection by exhaustion therefore needs LATENCY ≥ NUM_TAGS.
- Reset values of all outputs: Dmem2proc_response=0, Dmem2proc_tag=0, Dmem2proc_data=0.
- First request is accepted in the first cycle after reset deasserts.

## Test plan
- Store then load:
  - Reset; in cycle 0, STORE 64'h1122334455667788 to 0x100 → response 1.
  - LOAD 0x100 in cycle 1 → response 1; in cycle 5, Dmem2proc_tag=1 and data=64'h1122334455667788; in cycle 6, tag=0.
- Address masking: LOAD 0x105 and LOAD 0x10100 → both return the word stored at 0x100.
- Tag exhaustion (LATENCY=20):
  - LOADs in cycles 0–14 → responses 1..15; LOAD in cycle 15 → response 0, no state change.
  - Tag 1 returns in cycle 20; LOAD in cycle 20 → response 0; LOAD in cycle 21 → response 1.
- Load/store race: LOAD 0x200 (old value A) in cycle 0, STORE B to 0x200 in cycle 1 → cycle-4 broadcast carries A; a LOAD in cycle 2 returns B.
- Mid-flight reset:
  - Three loads outstanding; pull reset low mid-cycle → tag/data outputs drop to 0 without waiting for a clock edge.
  - After release, no stale tag appears for 2×LATENCY cycles and the next LOAD gets response 1.
- Idle commands: command 0 or 3 with arbitrary addr/data → response 0, array unchanged, no broadcasts.
